// File: rtl/sensor_stat_if.sv
// Bundle between the sensor controller (master: clear, sample strobe and data)
// and the statistics tracker (slave: registered per-channel statistics).
//   clr          master->slave  synchronous clear of all statistics
//   sample_valid master->slave  one-cycle sample strobe
//   sample_data  master->slave  packed samples, channel k = [k*DW +: DW]
//   max_data     slave->master  per-channel running maximum
//   min_data     slave->master  per-channel running minimum
//   avg_data     slave->master  per-channel moving average
//   ch_valid     slave->master  channel has accepted at least one sample
//   reject       slave->master  one-cycle pulse per out-of-range channel
//   sample_cnt   slave->master  saturating count of accepted strobes
//   upd          slave->master  one-cycle pulse, outputs reflect newest strobe
interface sensor_stat_if #(
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int CNT_W = 16
);
    logic                clr;
    logic                sample_valid;
    logic [NCH*DW-1:0]   sample_data;
    logic [NCH*DW-1:0]   max_data;
    logic [NCH*DW-1:0]   min_data;
    logic [NCH*DW-1:0]   avg_data;
    logic [NCH-1:0]      ch_valid;
    logic [NCH-1:0]      reject;
    logic [CNT_W-1:0]    sample_cnt;
    logic                upd;

    modport master (
        output clr, sample_valid, sample_data,
        input  max_data, min_data, avg_data, ch_valid, reject, sample_cnt, upd
    );

    modport slave (
        input  clr, sample_valid, sample_data,
        output max_data, min_data, avg_data, ch_valid, reject, sample_cnt, upd
    );
endinterface

// File: rtl/sensor_stat_tracker.sv
// Per-channel statistics engine for sensor samples: running max/min, a
// 2^AVG_LOG2-deep moving average per channel and a saturating sample count.
// Samples above LIM_MAX are rejected per channel without touching its state.
//   clk    system clock
//   reset  asynchronous, active-high reset
//   sif    sensor_stat_if slave modport (strobe/data in, statistics out)
// All outputs are registered; they reflect a strobe one clock after it.
module sensor_stat_tracker #(
    parameter int NCH      = 2,
    parameter int DW       = 8,
    parameter int AVG_LOG2 = 3,
    parameter int LIM_MAX  = 99,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    sensor_stat_if.slave  sif
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = DW + AVG_LOG2;

    logic [DW-1:0]       samp     [NCH];

    logic [DW-1:0]       max_q    [NCH];
    logic [DW-1:0]       max_d    [NCH];
    logic [DW-1:0]       min_q    [NCH];
    logic [DW-1:0]       min_d    [NCH];
    logic [DW-1:0]       avg_q    [NCH];
    logic [DW-1:0]       avg_d    [NCH];
    logic [SW-1:0]       sum_q    [NCH];
    logic [SW-1:0]       sum_d    [NCH];
    logic [AVG_LOG2-1:0] ptr_q    [NCH];
    logic [AVG_LOG2-1:0] ptr_d    [NCH];
    logic [DW-1:0]       buf_q    [NCH][DEPTH];
    logic [DW-1:0]       buf_d    [NCH][DEPTH];
    logic [NCH-1:0]      ch_valid_q, ch_valid_d;
    logic [NCH-1:0]      reject_q, reject_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                upd_q, upd_d;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            samp[k] = sif.sample_data[k*DW +: DW];
        end
    end

    always_comb begin
        max_d      = max_q;
        min_d      = min_q;
        sum_d      = sum_q;
        ptr_d      = ptr_q;
        buf_d      = buf_q;
        ch_valid_d = ch_valid_q;
        cnt_d      = cnt_q;
        reject_d   = '0;
        upd_d      = 1'b0;

        if (sif.clr) begin
            ch_valid_d = '0;
            cnt_d      = '0;
            for (int k = 0; k < NCH; k++) begin
                max_d[k] = '0;
                min_d[k] = '1;
                sum_d[k] = '0;
                ptr_d[k] = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    buf_d[k][i] = '0;
                end
            end
        end else if (sif.sample_valid) begin
            upd_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            for (int k = 0; k < NCH; k++) begin
                if (int'(samp[k]) > LIM_MAX) begin
                    reject_d[k] = 1'b1;
                end else begin
                    if (samp[k] > max_q[k]) max_d[k] = samp[k];
                    if (samp[k] < min_q[k]) min_d[k] = samp[k];
                    // ch_valid doubles as the "buffer holds real data" flag:
                    // the first accepted sample preloads the whole window so
                    // the average is meaningful from the first strobe.
                    if (!ch_valid_q[k]) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            buf_d[k][i] = samp[k];
                        end
                        sum_d[k] = SW'(samp[k]) << AVG_LOG2;
                        ptr_d[k] = AVG_LOG2'(1);
                    end else begin
                        // sum always covers buf[ptr], so no underflow here
                        sum_d[k] = sum_q[k] - SW'(buf_q[k][ptr_q[k]]) + SW'(samp[k]);
                        buf_d[k][ptr_q[k]] = samp[k];
                        ptr_d[k] = ptr_q[k] + AVG_LOG2'(1);
                    end
                    ch_valid_d[k] = 1'b1;
                end
            end
        end

        for (int k = 0; k < NCH; k++) begin
            avg_d[k] = sum_d[k][SW-1:AVG_LOG2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_valid_q <= '0;
            reject_q   <= '0;
            cnt_q      <= '0;
            upd_q      <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                max_q[k] <= '0;
                min_q[k] <= '1;
                avg_q[k] <= '0;
                sum_q[k] <= '0;
                ptr_q[k] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    buf_q[k][i] <= '0;
                end
            end
        end else begin
            ch_valid_q <= ch_valid_d;
            reject_q   <= reject_d;
            cnt_q      <= cnt_d;
            upd_q      <= upd_d;
            max_q      <= max_d;
            min_q      <= min_d;
            avg_q      <= avg_d;
            sum_q      <= sum_d;
            ptr_q      <= ptr_d;
            buf_q      <= buf_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_out
        assign sif.max_data[k*DW +: DW] = max_q[k];
        assign sif.min_data[k*DW +: DW] = min_q[k];
        assign sif.avg_data[k*DW +: DW] = avg_q[k];
    end

    assign sif.ch_valid   = ch_valid_q;
    assign sif.reject     = reject_q;
    assign sif.sample_cnt = cnt_q;
    assign sif.upd        = upd_q;
endmodule

// File: tb/tb_sensor_stat_tracker.sv
// Directed and randomized bench for sensor_stat_tracker (NCH=2, DW=8,
// AVG_LOG2=2, LIM_MAX=99, CNT_W=4). The reference keeps the list of accepted
// samples per channel and derives max/min/average from that history.
module tb_sensor_stat_tracker;
    localparam int NCH = 2;
    localparam int DW = 8;
    localparam int AVG_LOG2 = 2;
    localparam int LIM_MAX = 99;
    localparam int CNT_W = 4;
    localparam int WIN = 1 << AVG_LOG2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int HMAX = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;

    sensor_stat_if #(.NCH(NCH), .DW(DW), .CNT_W(CNT_W)) sif ();

    sensor_stat_tracker #(
        .NCH(NCH), .DW(DW), .AVG_LOG2(AVG_LOG2), .LIM_MAX(LIM_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    int ntotal = 0;
    int npass = 0;

    // reference model: accepted-sample history per channel plus strobe count
    int hv [NCH][HMAX];
    int hn [NCH];
    int cnt_m;
    int upd_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) hn[k] = 0;
        cnt_m = 0;
    endtask

    function automatic int m_max(input int ch);
        int r = 0;
        for (int i = 0; i < hn[ch]; i++) if (hv[ch][i] > r) r = hv[ch][i];
        return r;
    endfunction

    function automatic int m_min(input int ch);
        int r = (1 << DW) - 1;
        for (int i = 0; i < hn[ch]; i++) if (hv[ch][i] < r) r = hv[ch][i];
        return r;
    endfunction

    // window = last WIN accepted samples; slots never written since the
    // first sample still hold that first sample
    function automatic int m_avg(input int ch);
        int s = 0;
        int idx;
        if (hn[ch] == 0) return 0;
        for (int j = 0; j < WIN; j++) begin
            idx = hn[ch] - 1 - j;
            if (idx < 0) idx = 0;
            s += hv[ch][idx];
        end
        return s / WIN;
    endfunction

    task automatic check_all(input string tag);
        logic [NCH-1:0] vexp;
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("%s max%0d", tag, k), 32'(sif.max_data[k*DW +: DW]), 32'(m_max(k)));
            check($sformatf("%s min%0d", tag, k), 32'(sif.min_data[k*DW +: DW]), 32'(m_min(k)));
            check($sformatf("%s avg%0d", tag, k), 32'(sif.avg_data[k*DW +: DW]), 32'(m_avg(k)));
            vexp[k] = (hn[k] != 0);
        end
        check({tag, " ch_valid"}, 32'(sif.ch_valid), 32'(vexp));
        check({tag, " cnt"}, 32'(sif.sample_cnt), 32'(cnt_m));
    endtask

    task automatic strobe(input string tag, input logic [7:0] d0, input logic [7:0] d1, input logic c);
        logic [NCH-1:0] rexp;
        logic [7:0] dv [NCH];
        dv[0] = d0;
        dv[1] = d1;
        @(negedge clk);
        sif.sample_valid = 1'b1;
        sif.sample_data = {d1, d0};
        sif.clr = c;
        @(posedge clk);
        #1;
        sif.sample_valid = 1'b0;
        sif.clr = 1'b0;
        rexp = '0;
        if (c) begin
            model_clear();
        end else begin
            if (cnt_m < CNT_MAX) cnt_m++;
            for (int k = 0; k < NCH; k++) begin
                if (int'(dv[k]) > LIM_MAX) rexp[k] = 1'b1;
                else begin
                    hv[k][hn[k]] = int'(dv[k]);
                    hn[k]++;
                end
            end
        end
        if (sif.upd === 1'b1) upd_seen++;
        check({tag, " upd"}, 32'(sif.upd), c ? 32'd0 : 32'd1);
        check({tag, " reject"}, 32'(sif.reject), 32'(rexp));
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        @(posedge clk);
        #1;
        check({tag, " upd idle"}, 32'(sif.upd), 32'd0);
        check({tag, " reject idle"}, 32'(sif.reject), 32'd0);
    endtask

    task automatic do_clr(input string tag);
        @(negedge clk);
        sif.clr = 1'b1;
        @(posedge clk);
        #1;
        sif.clr = 1'b0;
        model_clear();
        check({tag, " upd"}, 32'(sif.upd), 32'd0);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] r0, r1;
        sif.clr = 1'b0;
        sif.sample_valid = 1'b0;
        sif.sample_data = '0;
        model_clear();
        upd_seen = 0;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset upd", 32'(sif.upd), 32'd0);
        check("reset reject", 32'(sif.reject), 32'd0);
        check_all("reset");

        // ch0 averaging: avg 25, 26, 25
        strobe("avg s1", 8'd25, 8'd0, 1'b0);
        check("avg s1 literal", 32'(sif.avg_data[7:0]), 32'd25);
        strobe("avg s2", 8'd30, 8'd0, 1'b0);
        check("avg s2 literal", 32'(sif.avg_data[7:0]), 32'd26);
        strobe("avg s3", 8'd20, 8'd0, 1'b0);
        check("avg s3 literal", 32'(sif.avg_data[7:0]), 32'd25);
        check("avg max literal", 32'(sif.max_data[7:0]), 32'd30);
        check("avg min literal", 32'(sif.min_data[7:0]), 32'd20);
        idle("avg");

        // ch1 range rejection
        do_clr("rej clr");
        strobe("rej s1", 8'd10, 8'd50, 1'b0);
        strobe("rej s2", 8'd60, 8'd120, 1'b0);
        check("rej reject literal", 32'(sif.reject), 32'b10);
        check("rej ch1 avg literal", 32'(sif.avg_data[15:8]), 32'd50);
        check("rej cnt literal", 32'(sif.sample_cnt), 32'd2);
        idle("rej");

        // clr collides with a strobe
        strobe("coll", 8'd40, 8'd40, 1'b1);
        strobe("coll next", 8'd40, 8'd40, 1'b0);
        check("coll avg literal", 32'(sif.avg_data[7:0]), 32'd40);
        check("coll cnt literal", 32'(sif.sample_cnt), 32'd1);

        // counter saturation with back-to-back strobes
        do_clr("sat clr");
        upd_seen = 0;
        for (int i = 0; i < 17; i++) begin
            r0 = 8'($urandom_range(0, 99));
            r1 = 8'($urandom_range(0, 99));
            strobe("sat", r0, r1, 1'b0);
        end
        check("sat cnt literal", 32'(sif.sample_cnt), 32'd15);
        check("sat upd pulses", 32'(upd_seen), 32'd17);
        idle("sat");

        // random mix around the limit
        for (int i = 0; i < 60; i++) begin
            r0 = 8'($urandom_range(0, 130));
            r1 = 8'($urandom_range(0, 130));
            if ($urandom_range(0, 9) == 0) strobe("rnd clr", r0, r1, 1'b1);
            else strobe("rnd", r0, r1, 1'b0);
            if ($urandom_range(0, 3) == 0) idle("rnd");
        end

        // asynchronous reset between edges
        strobe("ar pre", 8'd55, 8'd66, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check("ar upd", 32'(sif.upd), 32'd0);
        check_all("ar");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        strobe("ar post", 8'd77, 8'd33, 1'b0);
        check("ar post avg literal", 32'(sif.avg_data[7:0]), 32'd77);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
